match_controller: RTL and testbench
===================================

# match_controller

Sequences a Pong match around the ball/paddle datapath. The block generates the slowed game tick and gates ball motion with `run`. It judges paddle hits and misses at the paddle lines, keeps both scores, and drives serve and game-over. It sits between the top level and the ball/paddle state register block: it consumes pad and ball positions and returns tick, run, serve and bounce commands.

## Interface
Parameters:
- TICK_DIV, 131072, clk cycles per game tick (≥2)
- SERVE_DELAY, 64, ticks ball is held at centre before play (≥1)
- WIN_SCORE, 9, points that end the match (1..15)
- PAD_HEIGHT, 48, paddle height in pixels
- PAD_X_LEFT, 20, ball_x at or below which left paddle is judged
- PAD_X_RIGHT, 610, ball_x at or above which right paddle is judged (> PAD_X_LEFT)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  level; begins or restarts a match
- ball_x  in  10  ball column
- ball_y  in  9  ball row
- pad_left  in  10  left paddle top row
- pad_right  in  10  right paddle top row
- tick  out  1  one-clk game tick pulse
- run  out  1  ball motion enable
- serve  out  1  one-clk pulse: datapath reloads ball to centre
- serve_dir  out  1  0 = serve toward left, 1 = toward right
- bounce_x  out  1  one-clk pulse: datapath reverses ball x velocity
- score_left  out  4  left player score
- score_right  out  4  right player score
- game_over  out  1  match finished
- winner  out  1  0 = left, 1 = right; valid while game_over
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

## Operation
- Tick divider: counter 0..TICK_DIV-1, free-running in every state. `tick`=1 in the cycle after the counter equals TICK_DIV-1 (registered).
- IDLE: run=0, scores hold 0. start=1 → SERVE; serve pulse; serve_dir=1.
- SERVE: run=0. Counts `tick` pulses. On the SERVE_DELAY-th tick → PLAY, and both sides are armed.
- PLAY: run=1. Evaluated only in cycles where tick=1.
  - Left zone: left armed and ball_x ≤ PAD_X_LEFT.
    - Hit if pad_left ≤ ball_y < pad_left+PAD_HEIGHT. The sum is computed 11-bit; no wrap.
    - Hit → bounce_x pulse; left disarmed.
    - Miss → right scores; POINT.
  - Right zone: mirror using pad_right and PAD_X_RIGHT. Miss → left scores.
  - Re-arm: a disarmed side re-arms when PAD_X_LEFT < ball_x < PAD_X_RIGHT. This gives one bounce per contact.
  - Both zones cannot be true at once, given the parameter constraint. Left is checked first regardless.
- POINT (one clk):
  - Increment the scorer's score, saturating at 15. run=0.
  - If the new score == WIN_SCORE → OVER, with game_over=1 and winner=scorer.
  - Otherwise → SERVE, with a serve pulse and serve_dir toward the player who conceded.
- OVER: run=0; scores, winner and game_over held. start=1 → clear scores and game_over, then SERVE with a serve pulse and serve_dir=1.
- start is ignored in SERVE, PLAY and POINT.

## Timing
- Reset values: counter 0, tick 0, state IDLE, run 0, serve 0, serve_dir 1, bounce_x 0, scores 0, game_over 0, winner 0, both sides armed.
- All outputs are registered. Decisions are taken on the edge where tick=1 is sampled; bounce_x, serve and the state change appear the next cycle.
- run changes on the same edge as the state change.
- serve and bounce_x are exactly 1 clk wide and never asserted in the same cycle.
- Inputs are sampled only on tick cycles in PLAY; they may change freely otherwise.
- Reset mid-operation (any state) returns all of the above immediately (asynchronous). No pulse is emitted after release until the next start.

## Test plan
- TICK_DIV=4, rst released: tick pulses every 4th clk, 1 clk wide; state=0, run=0.
- SERVE_DELAY=2, start=1 in IDLE: serve 1-clk pulse, serve_dir=1, state=1. run=1 one clk after the 2nd tick.
- PLAY, pad_left=100, ball_x=20, ball_y=110:
  - On tick, a single bounce_x pulse; scores unchanged.
  - Holding ball_x=20 for 3 more ticks gives no further bounce_x.
  - Moving ball_x to 300 and back to 20 gives a new pulse.
- PLAY, pad_left=100, ball_x=15, ball_y=148 (edge miss):
  - score_right=1, run=0.
  - serve pulse with serve_dir=0; state passes 3 → 1.
- WIN_SCORE=3, three right-side misses: score_left=3, game_over=1, winner=0, state=4. start then clears scores and serves with serve_dir=1.
- rst asserted mid-PLAY with score 2:1: all outputs at reset values within the same cycle. start=0 afterwards keeps state=0 and gives no serve.

Source files
------------

// File: rtl/match_controller.sv
// Pong match sequencer: divides clk down to the game tick, gates ball motion,
// judges paddle contacts at the paddle lines, keeps score and drives serve/game-over.
module match_controller #(
  parameter int TICK_DIV    = 131072,
  parameter int SERVE_DELAY = 64,
  parameter int WIN_SCORE   = 9,
  parameter int PAD_HEIGHT  = 48,
  parameter int PAD_X_LEFT  = 20,
  parameter int PAD_X_RIGHT = 610
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [9:0] pad_left,
  input  logic [9:0] pad_right,
  output logic       tick,
  output logic       run,
  output logic       serve,
  output logic       serve_dir,
  output logic       bounce_x,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SC_W  = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  state_t            st;
  logic [CNT_W-1:0]  tick_cnt;
  logic [SC_W-1:0]   serve_cnt;
  logic              armed_left;
  logic              armed_right;
  logic              scorer;

  assign state = st;

  // Paddle spans are formed in 11 bits so a paddle near the bottom never wraps.
  logic [10:0] ball_y_w;
  logic [10:0] pad_left_end;
  logic [10:0] pad_right_end;
  logic        hit_left;
  logic        hit_right;
  logic        zone_left;
  logic        zone_right;
  logic        mid_court;
  logic [3:0]  cur_score;
  logic [3:0]  next_score;

  assign ball_y_w      = {2'b00, ball_y};
  assign pad_left_end  = {1'b0, pad_left}  + 11'(PAD_HEIGHT);
  assign pad_right_end = {1'b0, pad_right} + 11'(PAD_HEIGHT);
  assign hit_left      = (ball_y_w >= {1'b0, pad_left})  && (ball_y_w < pad_left_end);
  assign hit_right     = (ball_y_w >= {1'b0, pad_right}) && (ball_y_w < pad_right_end);
  assign zone_left     = armed_left  && (ball_x <= 10'(PAD_X_LEFT));
  assign zone_right    = armed_right && (ball_x >= 10'(PAD_X_RIGHT));
  assign mid_court     = (ball_x > 10'(PAD_X_LEFT)) && (ball_x < 10'(PAD_X_RIGHT));
  assign cur_score     = scorer ? score_right : score_left;
  assign next_score    = (cur_score == 4'hF) ? cur_score : cur_score + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      tick <= (tick_cnt == CNT_W'(TICK_DIV - 1));
      if (tick_cnt == CNT_W'(TICK_DIV - 1)) tick_cnt <= '0;
      else                                  tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      run         <= 1'b0;
      serve       <= 1'b0;
      serve_dir   <= 1'b1;
      bounce_x    <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      armed_left  <= 1'b1;
      armed_right <= 1'b1;
      serve_cnt   <= '0;
      scorer      <= 1'b0;
    end else begin
      serve    <= 1'b0;
      bounce_x <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            st        <= SERVE;
            serve     <= 1'b1;
            serve_dir <= 1'b1;
            serve_cnt <= '0;
          end
        end
        SERVE: begin
          if (tick) begin
            if (serve_cnt == SC_W'(SERVE_DELAY - 1)) begin
              st          <= PLAY;
              run         <= 1'b1;
              armed_left  <= 1'b1;
              armed_right <= 1'b1;
            end else begin
              serve_cnt <= serve_cnt + SC_W'(1);
            end
          end
        end
        PLAY: begin
          if (tick) begin
            if (zone_left) begin
              if (hit_left) begin
                bounce_x   <= 1'b1;
                armed_left <= 1'b0;
              end else begin
                scorer <= 1'b1;
                st     <= POINT;
                run    <= 1'b0;
              end
            end else if (zone_right) begin
              if (hit_right) begin
                bounce_x    <= 1'b1;
                armed_right <= 1'b0;
              end else begin
                scorer <= 1'b0;
                st     <= POINT;
                run    <= 1'b0;
              end
            end else if (mid_court) begin
              armed_left  <= 1'b1;
              armed_right <= 1'b1;
            end
          end
        end
        POINT: begin
          if (scorer) score_right <= next_score;
          else        score_left  <= next_score;
          if (next_score == 4'(WIN_SCORE)) begin
            st        <= OVER;
            game_over <= 1'b1;
            winner    <= scorer;
          end else begin
            // The player who conceded receives the next serve.
            st        <= SERVE;
            serve     <= 1'b1;
            serve_dir <= ~scorer;
            serve_cnt <= '0;
          end
        end
        OVER: begin
          if (start) begin
            score_left  <= '0;
            score_right <= '0;
            game_over   <= 1'b0;
            st          <= SERVE;
            serve       <= 1'b1;
            serve_dir   <= 1'b1;
            serve_cnt   <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed scenarios plus randomized rallies checked
// against a rally-level reference of the match rules.
module tb_match_controller;

  localparam int TICK_DIV    = 4;
  localparam int SERVE_DELAY = 2;
  localparam int WIN_SCORE   = 3;
  localparam int PAD_HEIGHT  = 48;
  localparam int PAD_X_LEFT  = 20;
  localparam int PAD_X_RIGHT = 610;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] ball_x = '0;
  logic [8:0] ball_y = '0;
  logic [9:0] pad_left = '0;
  logic [9:0] pad_right = '0;
  logic       tick, run, serve, serve_dir, bounce_x, game_over, winner;
  logic [3:0] score_left, score_right;
  logic [2:0] state;

  match_controller #(
    .TICK_DIV(TICK_DIV), .SERVE_DELAY(SERVE_DELAY), .WIN_SCORE(WIN_SCORE),
    .PAD_HEIGHT(PAD_HEIGHT), .PAD_X_LEFT(PAD_X_LEFT), .PAD_X_RIGHT(PAD_X_RIGHT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .pad_left(pad_left), .pad_right(pad_right),
    .tick(tick), .run(run), .serve(serve), .serve_dir(serve_dir), .bounce_x(bounce_x),
    .score_left(score_left), .score_right(score_right),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the match: scores, arming and game-over flag.
  int sc[2];
  bit armed[2];
  bit over_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_tick"}, 32'(tick), 0);
    check({tag, "_run"}, 32'(run), 0);
    check({tag, "_serve"}, 32'(serve), 0);
    check({tag, "_serve_dir"}, 32'(serve_dir), 1);
    check({tag, "_bounce"}, 32'(bounce_x), 0);
    check({tag, "_score_l"}, 32'(score_left), 0);
    check({tag, "_score_r"}, 32'(score_right), 0);
    check({tag, "_game_over"}, 32'(game_over), 0);
    check({tag, "_winner"}, 32'(winner), 0);
  endtask

  // Called at the falling edge where a serve pulse is expected.
  task automatic serve_phase(input bit exp_dir);
    int ticks = 0;
    int n = 0;
    check("serve_pulse", 32'(serve), 1);
    check("serve_dir", 32'(serve_dir), 32'(exp_dir));
    check("serve_state", 32'(state), 1);
    check("serve_run", 32'(run), 0);
    forever begin
      if (tick) ticks++;
      if (ticks == SERVE_DELAY || n > SERVE_DELAY * TICK_DIV * 2 + 8) break;
      @(negedge clk);
      n++;
      if (n == 1) check("serve_width", 32'(serve), 0);
    end
    check("serve_ticks", 32'(ticks), SERVE_DELAY);
    @(negedge clk);
    check("play_run", 32'(run), 1);
    check("play_state", 32'(state), 2);
    armed[0] = 1;
    armed[1] = 1;
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc[0] = 0;
    sc[1] = 0;
    over_m = 0;
    check("restart_score_l", 32'(score_left), 0);
    check("restart_score_r", 32'(score_right), 0);
    check("restart_game_over", 32'(game_over), 0);
    serve_phase(1'b1);
  endtask

  // One game tick in PLAY with the given positions; predicts the outcome from the rules.
  task automatic play_tick(input int x, input int y, input int pl, input int pr);
    bit exp_bounce = 0;
    bit point = 0;
    int who = 0;
    int n = 0;
    ball_x    = 10'(x);
    ball_y    = 9'(y);
    pad_left  = 10'(pl);
    pad_right = 10'(pr);
    start     = ($urandom_range(0, 3) == 0);
    while (!tick && n < TICK_DIV * 2) begin
      @(negedge clk);
      n++;
    end
    if (!tick) check("tick_wait", 0, 1);
    if (armed[0] && x <= PAD_X_LEFT) begin
      if (y >= pl && y < pl + PAD_HEIGHT) begin exp_bounce = 1; armed[0] = 0; end
      else begin point = 1; who = 1; end
    end else if (armed[1] && x >= PAD_X_RIGHT) begin
      if (y >= pr && y < pr + PAD_HEIGHT) begin exp_bounce = 1; armed[1] = 0; end
      else begin point = 1; who = 0; end
    end else if (x > PAD_X_LEFT && x < PAD_X_RIGHT) begin
      armed[0] = 1;
      armed[1] = 1;
    end
    @(negedge clk);
    start = 1'b0;
    check("bounce_x", 32'(bounce_x), 32'(exp_bounce));
    if (point) begin
      check("point_state", 32'(state), 3);
      check("point_run", 32'(run), 0);
      if (sc[who] < 15) sc[who]++;
      @(negedge clk);
      check("score_left", 32'(score_left), 32'(sc[0]));
      check("score_right", 32'(score_right), 32'(sc[1]));
      if (sc[who] == WIN_SCORE) begin
        over_m = 1;
        check("over_flag", 32'(game_over), 1);
        check("over_winner", 32'(winner), 32'(who));
        check("over_state", 32'(state), 4);
        check("over_run", 32'(run), 0);
      end else begin
        serve_phase(who == 0);
      end
    end else begin
      check("play_state_hold", 32'(state), 2);
    end
  endtask

  task automatic rand_tick();
    int x, y, pl, pr, off, pad;
    case ($urandom_range(0, 2))
      0:       x = $urandom_range(0, PAD_X_LEFT);
      1:       x = $urandom_range(PAD_X_RIGHT, 639);
      default: x = $urandom_range(PAD_X_LEFT + 1, PAD_X_RIGHT - 1);
    endcase
    pl  = ($urandom_range(0, 7) == 0) ? $urandom_range(470, 1023) : $urandom_range(0, 431);
    pr  = ($urandom_range(0, 7) == 0) ? $urandom_range(470, 1023) : $urandom_range(0, 431);
    pad = (x <= PAD_X_LEFT) ? pl : pr;
    off = int'($urandom_range(0, PAD_HEIGHT + 12)) - 6;
    y   = pad + off;
    if (y < 0 || y > 511) y = $urandom_range(0, 511);
    play_tick(x, y, pl, pr);
  endtask

  initial begin
    int k = 0;
    bit saw_serve = 0;
    sc[0] = 0; sc[1] = 0; armed[0] = 1; armed[1] = 1; over_m = 0;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Divider: tick high after every TICK_DIV-th edge since release, one clk wide.
    repeat (12) begin
      @(negedge clk);
      k++;
      check("tick_phase", 32'(tick), 32'((k % TICK_DIV) == 0));
      check("idle_state", 32'(state), 0);
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    serve_phase(1'b1);

    // Hit at the left line, then no repeat while the ball stays in the zone.
    play_tick(20, 110, 100, 0);
    check("hit_score_l", 32'(score_left), 0);
    check("hit_score_r", 32'(score_right), 0);
    repeat (3) play_tick(20, 110, 100, 0);
    play_tick(300, 110, 100, 0);
    play_tick(20, 110, 100, 0);

    // Bottom-edge miss on the left paddle: right scores, serve toward left.
    play_tick(300, 148, 100, 0);
    play_tick(15, 148, 100, 0);

    // Right-side misses until the left player wins.
    while (!over_m) play_tick(630, 200, 0, 0);
    check("win_left_score", 32'(score_left), WIN_SCORE);
    restart();

    // Reach 2:1, then reset asynchronously mid-rally.
    play_tick(630, 200, 0, 0);
    play_tick(630, 200, 0, 0);
    play_tick(15, 300, 100, 0);
    check("pre_reset_state", 32'(state), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (serve) saw_serve = 1;
    end
    check("post_reset_no_serve", 32'(saw_serve), 0);
    check("post_reset_idle", 32'(state), 0);

    // Randomized rallies, restarting whenever the match ends.
    restart();
    repeat (150) begin
      if (over_m) restart();
      rand_tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
